// File: rtl/step_seq_gen.sv
// Stepper coil-phase sequencer: turns a move command into the {A,B,a,b} phase-code
// stream at the commanded step rate and tracks the absolute step position.
module step_seq_gen #(
   parameter int POS_W = 16,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Enable,
   input  logic             start,
   input  logic             dir,
   input  logic             half_step,
   input  logic [POS_W-1:0] steps,
   input  logic [DIV_W-1:0] period,
   output logic             A,
   output logic             B,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             abort,
   output logic [POS_W-1:0] position
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
   localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

   // Only these eight codes are legal on the coil lines; anything else means de-energised.
   function automatic logic [3:0] phase_code(input logic [2:0] idx);
      logic [3:0] code;
      case (idx)
         3'd0:    code = 4'b1000;
         3'd1:    code = 4'b1010;
         3'd2:    code = 4'b0010;
         3'd3:    code = 4'b0110;
         3'd4:    code = 4'b0100;
         3'd5:    code = 4'b0101;
         3'd6:    code = 4'b0001;
         3'd7:    code = 4'b1001;
         default: code = 4'b0000;
      endcase
      return code;
   endfunction

   state_t           state_r, state_s;
   logic [2:0]       idx_r, idx_s;
   logic [POS_W-1:0] position_r, position_s;
   logic [POS_W-1:0] rem_r, rem_s;
   logic [DIV_W-1:0] timer_r, timer_s;
   logic [DIV_W-1:0] reload_r, reload_s;
   logic             dir_r, dir_s;
   logic             half_r, half_s;
   logic [3:0]       phase_r;
   logic             busy_r, done_r, abort_r;
   logic [2:0]       step_amt_s;
   logic [DIV_W-1:0] reload_in_s;

   // Next-state and datapath update for the move sequencer.
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      position_s  = position_r;
      rem_s       = rem_r;
      timer_s     = timer_r;
      reload_s    = reload_r;
      dir_s       = dir_r;
      half_s      = half_r;
      step_amt_s  = half_r ? 3'd1 : 3'd2;
      // A zero period behaves like one: step every cycle.
      reload_in_s = (period == DIV_ZERO) ? DIV_ZERO : (period - DIV_ONE);

      case (state_r)
         S_IDLE: begin
            if (start && Enable) begin
               if (steps != POS_ZERO) begin
                  state_s  = S_RUN;
                  dir_s    = dir;
                  half_s   = half_step;
                  rem_s    = steps;
                  reload_s = reload_in_s;
                  timer_s  = reload_in_s;
               end else begin
                  state_s = S_DONE;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (!Enable) begin
               state_s = S_IDLE;
            end else if (timer_r != DIV_ZERO) begin
               timer_s = timer_r - DIV_ONE;
            end else begin
               idx_s      = dir_r ? (idx_r + step_amt_s) : (idx_r - step_amt_s);
               position_s = dir_r ? (position_r + POS_ONE) : (position_r - POS_ONE);
               rem_s      = rem_r - POS_ONE;
               timer_s    = reload_r;
               state_s    = (rem_r == POS_ONE) ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; phases follow idx on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         idx_r      <= 3'd0;
         position_r <= POS_ZERO;
         rem_r      <= POS_ZERO;
         timer_r    <= DIV_ZERO;
         reload_r   <= DIV_ZERO;
         dir_r      <= 1'b0;
         half_r     <= 1'b0;
         phase_r    <= 4'b0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         abort_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         position_r <= position_s;
         rem_r      <= rem_s;
         timer_r    <= timer_s;
         reload_r   <= reload_s;
         dir_r      <= dir_s;
         half_r     <= half_s;
         phase_r    <= Enable ? phase_code(idx_s) : 4'b0000;
         busy_r     <= (state_s == S_RUN);
         done_r     <= (state_s == S_DONE);
         abort_r    <= (state_r == S_RUN) && !Enable;
      end
   end

   assign {A, B, a, b} = phase_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign abort        = abort_r;
   assign position     = position_r;

endmodule

// File: tb/tb_step_seq_gen.sv
// Directed, table-driven bench for step_seq_gen with hand-written abort and
// mid-move reset sequences.
module tb_step_seq_gen;

   localparam int POS_W = 16;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst, Enable, start, dir, half_step;
   logic [POS_W-1:0] steps;
   logic [DIV_W-1:0] period;
   logic             A, B, a, b, busy, done, abort;
   logic [POS_W-1:0] position;

   int n_cmp = 0;
   int n_bad = 0;

   step_seq_gen #(.POS_W(POS_W), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .Enable(Enable), .start(start), .dir(dir),
      .half_step(half_step), .steps(steps), .period(period),
      .A(A), .B(B), .a(a), .b(b), .busy(busy), .done(done), .abort(abort),
      .position(position)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        r;
      logic        en;
      logic        st;
      logic        dr;
      logic        hf;
      logic [15:0] stp;
      logic [15:0] per;
      logic [3:0]  ph;
      logic        bsy;
      logic        dn;
      logic        ab;
      logic [15:0] pos;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic en, input logic st, input logic dr,
                      input logic hf, input logic [15:0] stp, input logic [15:0] per,
                      input logic [3:0] ph, input logic bsy, input logic dn,
                      input logic ab, input logic [15:0] pos);
      vec_t v;
      v = '{r, en, st, dr, hf, stp, per, ph, bsy, dn, ab, pos};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] ph, input logic bsy,
                            input logic dn, input logic ab, input logic [15:0] pos);
      chk({tag, ".phase"}, {28'd0, A, B, a, b}, {28'd0, ph});
      chk({tag, ".busy"},  {31'd0, busy},  {31'd0, bsy});
      chk({tag, ".done"},  {31'd0, done},  {31'd0, dn});
      chk({tag, ".abort"}, {31'd0, abort}, {31'd0, ab});
      chk({tag, ".pos"},   {16'd0, position}, {16'd0, pos});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic en, input logic st, input logic dr,
                        input logic hf, input logic [15:0] stp, input logic [15:0] per);
      rst = r; Enable = en; start = st; dir = dr; half_step = hf;
      steps = stp; period = per;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();

      // reset state, then holding torque at idx 0
      add(1'b1,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0000,1'b0,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1000,1'b0,1'b0,1'b0,16'h0000);
      // forward half-step, 4 steps, period 3
      add(1'b0,1'b1,1'b1,1'b1,1'b1,16'd4,16'd3, 4'b1000,1'b1,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1000,1'b1,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1000,1'b1,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1010,1'b1,1'b0,1'b0,16'h0001);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1010,1'b1,1'b0,1'b0,16'h0001);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1010,1'b1,1'b0,1'b0,16'h0001);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0010,1'b1,1'b0,1'b0,16'h0002);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0010,1'b1,1'b0,1'b0,16'h0002);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0010,1'b1,1'b0,1'b0,16'h0002);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0110,1'b1,1'b0,1'b0,16'h0003);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0110,1'b1,1'b0,1'b0,16'h0003);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0110,1'b1,1'b0,1'b0,16'h0003);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0100,1'b0,1'b1,1'b0,16'h0004);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0100,1'b0,1'b0,1'b0,16'h0004);
      // reset back to idx 0, then reverse full-step, 3 steps, period 1, wrap
      add(1'b1,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0000,1'b0,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b1000,1'b0,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b1,1'b0,1'b0,16'd3,16'd1, 4'b1000,1'b1,1'b0,1'b0,16'h0000);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0001,1'b1,1'b0,1'b0,16'hFFFF);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0100,1'b1,1'b0,1'b0,16'hFFFE);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0010,1'b0,1'b1,1'b0,16'hFFFD);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0010,1'b0,1'b0,1'b0,16'hFFFD);
      // zero-step move: done only
      add(1'b0,1'b1,1'b1,1'b1,1'b1,16'd0,16'd7, 4'b0010,1'b0,1'b1,1'b0,16'hFFFD);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0010,1'b0,1'b0,1'b0,16'hFFFD);
      // 2-step move, period 2, extra starts while busy and in DONE are ignored
      add(1'b0,1'b1,1'b1,1'b1,1'b1,16'd2,16'd2, 4'b0010,1'b1,1'b0,1'b0,16'hFFFD);
      add(1'b0,1'b1,1'b1,1'b0,1'b0,16'd9,16'd1, 4'b0010,1'b1,1'b0,1'b0,16'hFFFD);
      add(1'b0,1'b1,1'b1,1'b0,1'b0,16'd9,16'd1, 4'b0110,1'b1,1'b0,1'b0,16'hFFFE);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0110,1'b1,1'b0,1'b0,16'hFFFE);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0100,1'b0,1'b1,1'b0,16'hFFFF);
      add(1'b0,1'b1,1'b1,1'b1,1'b1,16'd5,16'd1, 4'b0100,1'b0,1'b0,1'b0,16'hFFFF);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0100,1'b0,1'b0,1'b0,16'hFFFF);
      // Enable low in IDLE: de-energised, start refused
      add(1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0000,1'b0,1'b0,1'b0,16'hFFFF);
      add(1'b0,1'b0,1'b1,1'b1,1'b1,16'd3,16'd1, 4'b0000,1'b0,1'b0,1'b0,16'hFFFF);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,16'd0, 4'b0100,1'b0,1'b0,1'b0,16'hFFFF);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].en, tbl[i].st, tbl[i].dr, tbl[i].hf, tbl[i].stp, tbl[i].per);
         tick();
         check_out($sformatf("vec%0d", i), tbl[i].ph, tbl[i].bsy, tbl[i].dn, tbl[i].ab, tbl[i].pos);
      end

      // abort after the 2nd step of a 10-step, period-5 move
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd10, 16'd5);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk($sformatf("abrt_run%0d.done", c), {31'd0, done}, 32'd0);
      end
      check_out("abrt_pre", 4'b0010, 1'b1, 1'b0, 1'b0, 16'h0002);
      Enable = 1'b0;
      tick();
      check_out("abrt", 4'b0000, 1'b0, 1'b0, 1'b1, 16'h0002);
      Enable = 1'b1;
      tick();
      check_out("abrt_post", 4'b0010, 1'b0, 1'b0, 1'b0, 16'h0002);

      // Enable drops on the very cycle a step is due: step is suppressed
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5, 16'd2);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      check_out("edge_pre", 4'b0010, 1'b1, 1'b0, 1'b0, 16'h0002);
      Enable = 1'b0;
      tick();
      check_out("edge_abrt", 4'b0000, 1'b0, 1'b0, 1'b1, 16'h0002);
      Enable = 1'b1;
      tick();
      check_out("edge_post", 4'b0010, 1'b0, 1'b0, 1'b0, 16'h0002);

      // synchronous reset in the middle of a move
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd5, 16'd1);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      check_out("rst_pre", 4'b0100, 1'b1, 1'b0, 1'b0, 16'h0003);
      rst = 1'b1;
      tick();
      check_out("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      rst = 1'b0;
      tick();
      check_out("rst_post", 4'b1000, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      check_out("rst_quiet", 4'b1000, 1'b0, 1'b0, 1'b0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
